// File: rtl/calc_sequencer_pkg.sv
// Shared types and defaults for the calculator sequencer: FSM states, operator codes,
// operand width and the display error word.
package calc_sequencer_pkg;

   typedef enum logic [2:0] {
      ENTRY_A,
      OP_WAIT,
      ENTRY_B,
      CALC,
      RESULT,
      ERROR
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_RSVD = 2'b10,
      OP_CLR  = 2'b11
   } op_t;

   localparam int          NUM_DIGITS_DEF  = 4;
   localparam logic [15:0] ERR_PATTERN_DEF = 16'hFFFF;

endpackage

// File: rtl/calc_sequencer_digit_alu.sv
// One BCD digit of add/subtract with decimal correction; cout is carry on add, borrow on sub.
module bcd_digit_alu (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] y,
   output logic       cout
);

   logic [4:0] sum;
   logic [4:0] diff;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      diff = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
      y    = 4'd0;
      cout = 1'b0;
      if (sub) begin
         // Bit 4 of the 5-bit difference is the borrow; adding 10 wraps back into 0..9.
         cout = diff[4];
         y    = diff[4] ? diff[3:0] + 4'd10 : diff[3:0];
      end else begin
         cout = (sum > 5'd9);
         y    = (sum > 5'd9) ? sum[3:0] + 4'd6 : sum[3:0];
      end
   end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: keypad events -> packed-BCD operand entry, digit-serial
// add/subtract sequencing and the registered word/flags shown on the display.
module calc_sequencer
   import calc_sequencer_pkg::*;
#(
   parameter int                      NUM_DIGITS  = NUM_DIGITS_DEF,
   parameter logic [4*NUM_DIGITS-1:0] ERR_PATTERN = ERR_PATTERN_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    btn_press,
   input  logic                    is_num,
   input  logic                    is_op,
   input  logic                    is_eq,
   input  logic [3:0]              num_val,
   input  logic [1:0]              op_val,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic                    neg,
   output logic                    err,
   output logic                    busy
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int CW = $clog2(NUM_DIGITS + 1);

   state_t        state;
   op_t           pending_op, next_op;
   logic [W-1:0]  a, b, r;
   logic [CW-1:0] cnt_a, cnt_b, step;
   logic          btn_press_q, chain, neg_n, carry;

   logic          ev, ev_num, ev_eq, ev_arith, ev_clr;
   logic          app_a, app_b, is_sub, alu_cout;
   logic [3:0]    alu_y;
   logic [W-1:0]  digit_word, seed, r_next;
   logic [CW-1:0] digit_cnt;

   // One event per key: rising edge of the debounced level.
   assign ev       = btn_press & ~btn_press_q;
   assign ev_arith = ev & is_op & (op_val == OP_ADD || op_val == OP_SUB);
   assign ev_clr   = ev & is_op & (op_val == OP_CLR) & (state != CALC);
   assign ev_eq    = ev & ~is_op & is_eq;
   assign ev_num   = ev & ~is_op & ~is_eq & is_num & (num_val <= 4'd9);

   assign digit_word = {{(W-4){1'b0}}, num_val};
   assign digit_cnt  = (num_val != 4'd0) ? CW'(1) : '0;
   assign app_a      = (cnt_a != CW'(NUM_DIGITS)) && ((cnt_a != '0) || (num_val != 4'd0));
   assign app_b      = (cnt_b != CW'(NUM_DIGITS)) && ((cnt_b != '0) || (num_val != 4'd0));
   assign seed       = neg_n ? '0 : r;
   assign is_sub     = (pending_op == OP_SUB);
   assign r_next     = {alu_y, r[W-1:4]};

   bcd_digit_alu u_alu (
      .a    (a[3:0]),
      .b    (b[3:0]),
      .cin  (carry),
      .sub  (is_sub),
      .y    (alu_y),
      .cout (alu_cout)
   );

   // Clear re-arms everything except edge detection, so a held clear key acts once.
   always_ff @(posedge clk) begin
      if (rst) btn_press_q <= 1'b0;
      else     btn_press_q <= btn_press;
   end

   always_ff @(posedge clk) begin
      if (rst || ev_clr) begin
         state      <= ENTRY_A;
         a          <= '0;
         b          <= '0;
         r          <= '0;
         cnt_a      <= '0;
         cnt_b      <= '0;
         step       <= '0;
         pending_op <= OP_ADD;
         next_op    <= OP_ADD;
         chain      <= 1'b0;
         neg_n      <= 1'b0;
         carry      <= 1'b0;
         bcd_out    <= '0;
         neg        <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ENTRY_A: begin
               if (ev_num && app_a) begin
                  a       <= {a[W-5:0], num_val};
                  bcd_out <= {a[W-5:0], num_val};
                  cnt_a   <= cnt_a + CW'(1);
               end else if (ev_arith) begin
                  pending_op <= op_t'(op_val);
                  state      <= OP_WAIT;
               end
            end
            OP_WAIT: begin
               if (ev_num) begin
                  b       <= digit_word;
                  cnt_b   <= digit_cnt;
                  bcd_out <= digit_word;
                  state   <= ENTRY_B;
               end else if (ev_arith) begin
                  pending_op <= op_t'(op_val);
               end
            end
            ENTRY_B: begin
               if (ev_num && app_b) begin
                  b       <= {b[W-5:0], num_val};
                  bcd_out <= {b[W-5:0], num_val};
                  cnt_b   <= cnt_b + CW'(1);
               end else if (ev_eq || ev_arith) begin
                  chain   <= ev_arith;
                  next_op <= ev_arith ? op_t'(op_val) : OP_ADD;
                  step    <= '0;
                  busy    <= 1'b1;
                  state   <= CALC;
               end
            end
            CALC: begin
               if (step == '0) begin
                  // Operands are consumed in place; swap so the magnitude is always A-B >= 0.
                  if (is_sub && (a < b)) begin
                     a <= b;
                     b <= a;
                  end
                  neg_n <= is_sub && (a < b);
                  carry <= 1'b0;
                  step  <= CW'(1);
               end else begin
                  a     <= a >> 4;
                  b     <= b >> 4;
                  r     <= r_next;
                  carry <= alu_cout;
                  step  <= step + CW'(1);
                  if (step == CW'(NUM_DIGITS)) begin
                     busy <= 1'b0;
                     if (!is_sub && alu_cout) begin
                        err     <= 1'b1;
                        bcd_out <= ERR_PATTERN;
                        state   <= ERROR;
                     end else begin
                        bcd_out <= r_next;
                        neg     <= neg_n;
                        state   <= RESULT;
                     end
                  end
               end
            end
            RESULT: begin
               if (chain) begin
                  // Chained operator: result becomes A; a key landing this cycle acts as in OP_WAIT.
                  chain      <= 1'b0;
                  a          <= seed;
                  pending_op <= next_op;
                  neg        <= 1'b0;
                  bcd_out    <= seed;
                  state      <= OP_WAIT;
                  if (ev_num) begin
                     b       <= digit_word;
                     cnt_b   <= digit_cnt;
                     bcd_out <= digit_word;
                     state   <= ENTRY_B;
                  end else if (ev_arith) begin
                     pending_op <= op_t'(op_val);
                  end
               end else if (ev_num) begin
                  a       <= digit_word;
                  cnt_a   <= digit_cnt;
                  neg     <= 1'b0;
                  bcd_out <= digit_word;
                  state   <= ENTRY_A;
               end else if (ev_arith) begin
                  a          <= seed;
                  pending_op <= op_t'(op_val);
                  neg        <= 1'b0;
                  bcd_out    <= seed;
                  state      <= OP_WAIT;
               end
            end
            ERROR: begin
               err     <= 1'b1;
               bcd_out <= ERR_PATTERN;
            end
            default: state <= ENTRY_A;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed-vector bench for calc_sequencer: key sequences with hand-computed display words.
module tb_calc_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_press = 1'b0;
   logic        is_num = 1'b0;
   logic        is_op = 1'b0;
   logic        is_eq = 1'b0;
   logic [3:0]  num_val = 4'd0;
   logic [1:0]  op_val = 2'd0;
   logic [15:0] bcd_out;
   logic        neg, err, busy;

   int          n_checks = 0;
   int          n_pass = 0;
   int          hold_cyc = 1;
   logic [15:0] o_bcd;
   logic        o_neg, o_err, o_busy;
   int          o_busyc;

   calc_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .btn_press (btn_press),
      .is_num    (is_num),
      .is_op     (is_op),
      .is_eq     (is_eq),
      .num_val   (num_val),
      .op_val    (op_val),
      .bcd_out   (bcd_out),
      .neg       (neg),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Press a key for hold_cyc cycles; snapshot outputs 6 cycles after the event
   // and count busy cycles among the first 5.
   task automatic press(input logic f_op, input logic f_eq, input logic f_num, input logic [3:0] v);
      int last;
      last = (hold_cyc > 6) ? hold_cyc : 6;
      is_op = f_op; is_eq = f_eq; is_num = f_num;
      num_val = v; op_val = v[1:0];
      btn_press = 1'b1;
      o_busyc = 0;
      for (int k = 1; k <= last; k++) begin
         @(posedge clk); #1;
         if (k == hold_cyc) begin
            btn_press = 1'b0; is_op = 1'b0; is_eq = 1'b0; is_num = 1'b0;
         end
         if (k <= 5 && busy) o_busyc++;
         if (k == 6) begin
            o_bcd = bcd_out; o_neg = neg; o_err = err; o_busy = busy;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic key_num(input logic [3:0] v); press(1'b0, 1'b0, 1'b1, v); endtask
   task automatic key_op(input logic [1:0] v);  press(1'b1, 1'b0, 1'b0, {2'b00, v}); endtask
   task automatic key_eq();                     press(1'b0, 1'b1, 1'b0, 4'd0); endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_bcd", 32'(bcd_out), 32'h0);
      check("rst_neg", 32'(neg), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);

      // 1234 + 5678 = 6912
      key_num(1); key_num(2); key_num(3); key_num(4);
      check("entry_a_1234", 32'(o_bcd), 32'h1234);
      key_op(2'b00);
      key_num(5); key_num(6); key_num(7); key_num(8);
      check("entry_b_5678", 32'(o_bcd), 32'h5678);
      key_eq();
      check("add_bcd", 32'(o_bcd), 32'h6912);
      check("add_neg", 32'(o_neg), 0);
      check("add_busy_cycles", 32'(o_busyc), 5);
      check("add_busy_done", 32'(o_busy), 0);

      // 25 - 100 = -75, then a digit restarts entry
      key_op(2'b11);
      check("clear_bcd", 32'(o_bcd), 32'h0);
      key_num(2); key_num(5); key_op(2'b01);
      key_num(1); key_num(0); key_num(0);
      check("entry_b_100", 32'(o_bcd), 32'h0100);
      key_eq();
      check("sub_bcd", 32'(o_bcd), 32'h0075);
      check("sub_neg", 32'(o_neg), 1);
      key_num(3);
      check("after_sub_bcd", 32'(o_bcd), 32'h0003);
      check("after_sub_neg", 32'(o_neg), 0);

      // 9999 + 1 overflows
      key_op(2'b11);
      key_num(9); key_num(9); key_num(9); key_num(9); key_op(2'b00); key_num(1);
      key_eq();
      check("ovf_err", 32'(o_err), 1);
      check("ovf_bcd", 32'(o_bcd), 32'hFFFF);
      key_num(5);
      check("err_digit_bcd", 32'(o_bcd), 32'hFFFF);
      key_eq();
      check("err_eq_err", 32'(o_err), 1);
      key_op(2'b11);
      check("err_clear_bcd", 32'(o_bcd), 32'h0);
      check("err_clear_err", 32'(o_err), 0);

      // Chain 10 + 5 - 3 = 12 with long key holds
      hold_cyc = 50;
      key_num(1); key_num(0); key_op(2'b00); key_num(5);
      key_op(2'b01);
      check("chain_mid_bcd", 32'(o_bcd), 32'h0015);
      check("chain_mid_busy", 32'(o_busyc), 5);
      key_num(3);
      check("chain_b_bcd", 32'(o_bcd), 32'h0003);
      key_eq();
      check("chain_final_bcd", 32'(o_bcd), 32'h0012);
      check("chain_final_neg", 32'(o_neg), 0);
      hold_cyc = 1;

      // Entry limits, ignored codes, then 7123 + 1
      key_op(2'b11);
      key_num(0); key_num(0);
      check("lead_zero_bcd", 32'(o_bcd), 32'h0);
      key_num(7); key_num(1); key_num(2); key_num(3); key_num(4);
      check("limit_bcd", 32'(o_bcd), 32'h7123);
      key_op(2'b10);
      check("op_rsvd_bcd", 32'(o_bcd), 32'h7123);
      key_num(4'd12);
      check("num_12_bcd", 32'(o_bcd), 32'h7123);
      key_op(2'b00); key_num(1); key_eq();
      check("limit_sum_bcd", 32'(o_bcd), 32'h7124);

      // Operator wins over digit when both flags are set
      key_op(2'b11);
      press(1'b1, 1'b0, 1'b1, 4'd4);
      check("prio_bcd", 32'(o_bcd), 32'h0);
      key_num(8); key_eq();
      check("prio_sum_bcd", 32'(o_bcd), 32'h0008);

      // Reset in CALC cycle 2 of 4 + 5
      key_op(2'b11);
      key_num(4); key_op(2'b00); key_num(5);
      is_eq = 1'b1; btn_press = 1'b1;
      @(posedge clk); #1;
      btn_press = 1'b0; is_eq = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_calc_busy", 32'(busy), 1);
      check("mid_calc_bcd", 32'(bcd_out), 32'h0005);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_bcd", 32'(bcd_out), 32'h0);
      check("abort_busy", 32'(busy), 0);
      check("abort_neg", 32'(neg), 0);
      key_num(3); key_eq();
      check("abort_then_bcd", 32'(o_bcd), 32'h0003);
      check("abort_then_busy", 32'(o_busyc), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
